// File: rtl/tinynpu_pkg.sv
// rtl/tinynpu_pkg.sv - shared constants and drain FSM state type for the TinyNPU output stream
package tinynpu_pkg;

  localparam int DW_DEFAULT  = 16;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/tinynpu_ostream_buf.sv
// rtl/tinynpu_ostream_buf.sv - SIZE x DW capture register file; TINYNPU_OSTREAM_RELU_EN rectifies at write
module tinynpu_ostream_buf
  import tinynpu_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DW   = DW_DEFAULT,
  parameter int IW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] wdata [SIZE],
  input  logic [IW-1:0] rd_idx,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [SIZE];

  function automatic logic [DW-1:0] rectify(input logic [DW-1:0] v);
`ifdef TINYNPU_OSTREAM_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= rectify(wdata[i]);
    end
  end

  assign rdata = mem[rd_idx];

endmodule

// File: rtl/tinynpu_ostream_drain.sv
// rtl/tinynpu_ostream_drain.sv - captures SIZE MAC results and serializes them on a val/rdy channel (option: TINYNPU_OSTREAM_RELU_EN)
module tinynpu_ostream_drain
  import tinynpu_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DW   = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ostream_req,
  input  logic [DW-1:0]            mac_out [SIZE],
  input  logic                     out_rdy,
  output logic                     out_val,
  output logic [DW-1:0]            out_msg,
  output logic [$clog2(SIZE)-1:0]  out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     drop_err,
  output logic [FRAME_CNT_W-1:0]   frame_cnt
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  drain_state_t    state;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   rd_word;
  logic            fire;
  logic            last_fire;
  logic            capture;

  assign fire      = (state == DRAIN) && out_rdy;
  assign last_fire = fire && (idx == LAST_IDX);
  // A request is only honoured when the buffer is free or is being vacated this cycle.
  assign capture   = ostream_req && ((state == IDLE) || last_fire);

  tinynpu_ostream_buf #(
    .SIZE (SIZE),
    .DW   (DW)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .we     (capture),
    .wdata  (mac_out),
    .rd_idx (idx),
    .rdata  (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      drop_err  <= 1'b0;
    end else if (state == IDLE) begin
      if (ostream_req) begin
        state <= DRAIN;
        idx   <= '0;
      end
    end else begin
      if (ostream_req && !last_fire) drop_err <= 1'b1;
      if (fire) begin
        if (idx == LAST_IDX) begin
          frame_cnt <= frame_cnt + 1'b1;
          idx       <= '0;
          if (!ostream_req) state <= IDLE;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign out_val  = (state == DRAIN);
  assign busy     = (state == DRAIN);
  assign out_idx  = idx;
  assign out_msg  = out_val ? rd_word : '0;
  assign out_last = out_val && (idx == LAST_IDX);

endmodule
